// File: rtl/z80_mmu_pkg.sv
// z80_mmu_pkg: shared definitions for the clocked Z80 page-translation MMU.
// Holds the access FSM encoding, page-table flag positions and the identity
// entry flags written during table initialisation.
package z80_mmu_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_ACCESS = 3'd3,
    ST_TBL    = 3'd4,
    ST_FAULT  = 3'd5
  } mmu_state_t;

  // Flag bit positions within the entry flag field (above the page number)
  localparam int unsigned FLAG_V  = 0;
  localparam int unsigned FLAG_WP = 1;

  // Flags of every entry written during INIT: valid, all other flags clear
  localparam int unsigned INIT_FLAGS = 1 << FLAG_V;

endpackage

// File: rtl/z80_mmu_sync2.sv
// z80_mmu_sync2: 3-bit two-flop synchroniser for the active-low Z80 strobes.
// Resets to all-ones so no strobe appears asserted while in reset.
module z80_mmu_sync2 (
  input  logic       clk,
  input  logic       nRESET,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);

  logic [2:0] r_meta;
  logic [2:0] r_sync;

  // Two-stage capture of the asynchronous strobes
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/z80_mmu_sync.sv
// z80_mmu_sync: clocked Z80 page-translation MMU with a hardware-initialised
// page table, memory-mapped table window, and optional valid/write-protect
// fault checking enabled by defining MMU_FAULT_EN.
module z80_mmu_sync
  import z80_mmu_pkg::*;
#(
  parameter int unsigned    OFFSET_BITS = 8,
  parameter int unsigned    PA          = 12,
  parameter int unsigned    FLAGS       = 4,
  parameter logic [PA-1:0]  TBL_PAGE    = 'hFE
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic                      nMREQ,
  input  logic                      nRD,
  input  logic                      nWR,
  input  logic [15:0]               cpu_addr,
  input  logic [7:0]                cpu_data_in,
  output logic [7:0]                cpu_data_out,
  output logic                      cpu_data_oe,
  output logic                      nWAIT,
  output logic [PA+OFFSET_BITS-1:0] ram_addr,
  output logic                      ram_nCE,
  output logic                      ram_nOE,
  output logic                      ram_nWE,
  input  logic [7:0]                ram_data_in,
  output logic [7:0]                ram_data_out,
  output logic                      fault_irq,
  output logic [15:0]               fault_vaddr
);

  localparam int unsigned VPAGE_BITS = 16 - OFFSET_BITS;
  localparam int unsigned SIZE       = 1 << VPAGE_BITS;
  localparam int unsigned AW         = PA + OFFSET_BITS;
  localparam int unsigned WIN_BITS   = VPAGE_BITS + 1;  // window is 2*SIZE bytes
  localparam logic [AW-1:0] WIN_BASE = {TBL_PAGE, OFFSET_BITS'(0)};

  mmu_state_t r_state, w_next;

  logic [15:0]           r_table [SIZE];
  logic [15:0]           r_rd_entry;
  logic [VPAGE_BITS-1:0] r_init_idx;
  logic [15:0]           r_addr;
  logic [7:0]            r_data;
  logic                  r_wr;
  logic [PA-1:0]         r_page;

  logic [2:0]            w_sync;
  logic                  w_nmreq_s, w_nrd_s, w_nwr_s;
  logic                  w_start;
  logic [PA-1:0]         w_lk_page;
  logic [AW-1:0]         w_pa;
  logic                  w_in_win;
  logic [VPAGE_BITS-1:0] w_win_idx;
  logic                  w_byte_sel;
  logic [VPAGE_BITS-1:0] w_rd_idx;
  logic [15:0]           w_init_entry;
  logic                  w_fault;
  logic                  w_tbl_wr;

  z80_mmu_sync2 u_sync (
    .clk    (clk),
    .nRESET (nRESET),
    .i_d    ({nMREQ, nRD, nWR}),
    .o_q    (w_sync)
  );

  assign {w_nmreq_s, w_nrd_s, w_nwr_s} = w_sync;
  assign w_start = !w_nmreq_s && (!w_nrd_s || !w_nwr_s);

  // The translated page comes straight off the read port during LOOKUP and
  // from the latched copy afterwards, so one address path serves both.
  assign w_lk_page  = (r_state == ST_LOOKUP) ? r_rd_entry[PA-1:0] : r_page;
  assign w_pa       = {w_lk_page, r_addr[OFFSET_BITS-1:0]};
  assign w_in_win   = (w_pa[AW-1:WIN_BITS] == WIN_BASE[AW-1:WIN_BITS]);
  assign w_win_idx  = w_pa[WIN_BITS-1:1];
  assign w_byte_sel = w_pa[0];

  // IDLE reads the entry of the incoming virtual page; LOOKUP/TBL re-aim the
  // port at the window entry so TBL read-back data is ready on entry to TBL.
  always_comb begin
    w_rd_idx = r_addr[15:OFFSET_BITS];
    if (r_state == ST_IDLE)
      w_rd_idx = cpu_addr[15:OFFSET_BITS];
    else if (r_state == ST_LOOKUP || r_state == ST_TBL)
      w_rd_idx = w_win_idx;
  end

  assign w_init_entry = {FLAGS'(INIT_FLAGS), PA'(r_init_idx)};
  assign w_tbl_wr     = (r_state == ST_LOOKUP) && (w_next == ST_TBL) && r_wr;

`ifdef MMU_FAULT_EN
  assign w_fault = !r_rd_entry[PA+FLAG_V] || (r_rd_entry[PA+FLAG_WP] && r_wr);
`else
  assign w_fault = 1'b0;
`endif

  // Page table: single write port (INIT fill or window byte write), registered read
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)
      r_table[r_init_idx] <= w_init_entry;
    else if (w_tbl_wr) begin
      if (w_byte_sel)
        r_table[w_win_idx][15:8] <= r_data;
      else
        r_table[w_win_idx][7:0] <= r_data;
    end
    r_rd_entry <= r_table[w_rd_idx];
  end

  // FSM state, INIT counter and access capture registers
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_page     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT)
        r_init_idx <= r_init_idx + 1'b1;
      if (r_state == ST_IDLE && w_start) begin
        r_addr <= cpu_addr;
        r_data <= cpu_data_in;
        r_wr   <= !w_nwr_s;
      end
      if (r_state == ST_LOOKUP)
        r_page <= r_rd_entry[PA-1:0];
    end
  end

`ifdef MMU_FAULT_EN
  logic        r_fault_irq;
  logic [15:0] r_fault_vaddr;

  // Sticky fault report, cleared by any table write
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_fault_irq   <= 1'b0;
      r_fault_vaddr <= '0;
    end else if (r_state == ST_LOOKUP && w_next == ST_FAULT) begin
      r_fault_irq   <= 1'b1;
      r_fault_vaddr <= r_addr;
    end else if (w_tbl_wr) begin
      r_fault_irq   <= 1'b0;
    end
  end

  assign fault_irq   = r_fault_irq;
  assign fault_vaddr = r_fault_vaddr;
`else
  assign fault_irq   = 1'b0;
  assign fault_vaddr = '0;
`endif

  // Next-state and bus/RAM outputs decoded from the current state
  always_comb begin
    w_next       = r_state;
    ram_addr     = '0;
    ram_nCE      = 1'b1;
    ram_nOE      = 1'b1;
    ram_nWE      = 1'b1;
    ram_data_out = '0;
    cpu_data_out = '0;
    cpu_data_oe  = 1'b0;
    nWAIT        = 1'b1;
    case (r_state)
      ST_INIT: begin
        nWAIT = 1'b0;
        if (r_init_idx == VPAGE_BITS'(SIZE - 1))
          w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_start)
          w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_in_win)
          w_next = ST_TBL;
        else if (w_fault)
          w_next = ST_FAULT;
        else
          w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_addr = w_pa;
        ram_nCE  = 1'b0;
        if (r_wr) begin
          ram_nWE      = 1'b0;
          ram_data_out = r_data;
        end else begin
          ram_nOE      = 1'b0;
          cpu_data_out = ram_data_in;
          cpu_data_oe  = 1'b1;
        end
        if (w_nmreq_s)
          w_next = ST_IDLE;
      end
      ST_TBL: begin
        if (!r_wr) begin
          cpu_data_oe  = 1'b1;
          cpu_data_out = w_byte_sel ? r_rd_entry[15:8] : r_rd_entry[7:0];
        end
        if (w_nmreq_s)
          w_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (!r_wr) begin
          cpu_data_oe  = 1'b1;
          cpu_data_out = 8'hFF;
        end
        if (w_nmreq_s)
          w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_z80_mmu_sync.sv
// Testbench for z80_mmu_sync: directed steps from the test plan followed by
// random accesses, checked against a page-table model kept as a plain array.
module tb_z80_mmu_sync;

`ifdef MMU_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam int WIN = 'hFE00;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        nMREQ, nRD, nWR;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        cpu_data_oe, nWAIT;
  logic [19:0] ram_addr;
  logic        ram_nCE, ram_nOE, ram_nWE;
  logic [7:0]  ram_data_in, ram_data_out;
  logic        fault_irq;
  logic [15:0] fault_vaddr;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_tbl [256];
  logic        m_irq;
  logic [15:0] m_vaddr;

  logic [19:0] last_addr;
  logic        last_nce, last_noe, last_nwe, last_oe;
  logic [7:0]  last_data;

  z80_mmu_sync dut (
    .clk          (clk),
    .nRESET       (nRESET),
    .nMREQ        (nMREQ),
    .nRD          (nRD),
    .nWR          (nWR),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .nWAIT        (nWAIT),
    .ram_addr     (ram_addr),
    .ram_nCE      (ram_nCE),
    .ram_nOE      (ram_nOE),
    .ram_nWE      (ram_nWE),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .fault_irq    (fault_irq),
    .fault_vaddr  (fault_vaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tbl[i] = 16'h1000 | 16'(i);
    m_irq   = 1'b0;
    m_vaddr = '0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (nWAIT !== 1'b1 && n < 1000);
  endtask

  // One complete CPU access: drive strobes, check 4 clk later, release, check idle 3 clk later
  task automatic access(input logic [15:0] a, input bit wr, input bit both, input logic [7:0] d);
    int vp, pa, fl, off, idx;
    logic [7:0] rd;
    @(negedge clk);
    rd          = 8'($urandom);
    cpu_addr    = a;
    cpu_data_in = d;
    ram_data_in = rd;
    nMREQ       = 1'b0;
    nWR         = !wr;
    nRD         = wr ? !both : 1'b0;
    vp = int'(a[15:8]);
    pa = int'(m_tbl[vp][11:0]) * 256 + int'(a[7:0]);
    fl = int'(m_tbl[vp][15:12]);
    repeat (4) @(posedge clk);
    #1;
    last_addr = ram_addr; last_nce = ram_nCE; last_noe = ram_nOE;
    last_nwe = ram_nWE; last_oe = cpu_data_oe; last_data = cpu_data_out;
    if (pa >= WIN && pa < WIN + 512) begin
      off = pa - WIN;
      idx = off >> 1;
      chk("tbl_nce", 32'(ram_nCE), 1);
      chk("tbl_noe", 32'(ram_nOE), 1);
      chk("tbl_nwe", 32'(ram_nWE), 1);
      if (wr) begin
        chk("tbl_wr_oe", 32'(cpu_data_oe), 0);
        if (off % 2 == 1) m_tbl[idx][15:8] = d;
        else              m_tbl[idx][7:0]  = d;
        m_irq = 1'b0;
      end else begin
        chk("tbl_rd_oe", 32'(cpu_data_oe), 1);
        chk("tbl_rd_data", 32'(cpu_data_out),
            32'((off % 2 == 1) ? m_tbl[idx][15:8] : m_tbl[idx][7:0]));
      end
    end else if (FAULT_EN && ((fl % 2) == 0 || (wr && ((fl / 2) % 2) == 1))) begin
      chk("flt_nce", 32'(ram_nCE), 1);
      chk("flt_nwe", 32'(ram_nWE), 1);
      chk("flt_oe", 32'(cpu_data_oe), wr ? 0 : 1);
      if (!wr) chk("flt_data", 32'(cpu_data_out), 32'hFF);
      m_irq   = 1'b1;
      m_vaddr = a;
    end else begin
      chk("acc_addr", 32'(ram_addr), 32'(pa));
      chk("acc_nce", 32'(ram_nCE), 0);
      chk("acc_noe", 32'(ram_nOE), wr ? 1 : 0);
      chk("acc_nwe", 32'(ram_nWE), wr ? 0 : 1);
      if (wr) chk("acc_wdata", 32'(ram_data_out), 32'(d));
      else    chk("acc_rdata", 32'(cpu_data_out), 32'(rd));
    end
    chk("fault_irq", 32'(fault_irq), 32'(m_irq));
    chk("fault_vaddr", 32'(fault_vaddr), 32'(m_vaddr));
    @(negedge clk);
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel_nce", 32'(ram_nCE), 1);
    chk("rel_nrdwr", 32'({ram_nOE, ram_nWE}), 32'b11);
    chk("rel_oe", 32'(cpu_data_oe), 0);
  endtask

  initial begin
    int n;
    int r;
    nRESET = 1'b0; nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    cpu_addr = '0; cpu_data_in = '0; ram_data_in = '0;
    model_reset();
    #2;
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_strobes", 32'({ram_nCE, ram_nOE, ram_nWE}), 32'b111);
    chk("rst_oe", 32'(cpu_data_oe), 0);
    chk("rst_dout", 32'(cpu_data_out), 0);
    chk("rst_ram_dout", 32'(ram_data_out), 0);
    chk("rst_nwait", 32'(nWAIT), 0);
    chk("rst_irq", 32'(fault_irq), 0);
    chk("rst_vaddr", 32'(fault_vaddr), 0);
    @(negedge clk);
    nRESET = 1'b1;
    wait_init(n);
    chk("init_len", 32'(n), 256);

    // Identity read after INIT
    access(16'h12AB, 1'b0, 1'b0, 8'h00);
    chk("plan_12ab_addr", 32'(last_addr), 32'h012AB);
    chk("plan_12ab_noe", 32'(last_noe), 0);

    // Remap entry 0xAC to page 0x134 through the window
    access(16'hFF58, 1'b1, 1'b0, 8'h34);
    access(16'hFF59, 1'b1, 1'b0, 8'h01);
    access(16'hACFF, 1'b1, 1'b0, 8'h5A);
    if (!FAULT_EN) begin
      chk("plan_acff_addr", 32'(last_addr), 32'h134FF);
      chk("plan_acff_nwe", 32'(last_nwe), 0);
    end
    access(16'hFF58, 1'b0, 1'b0, 8'h00);
    chk("plan_rb_data", 32'(last_data), 32'h34);
    chk("plan_rb_nce", 32'(last_nce), 1);

    // Entry 0x20: WP=1, V=0
    access(16'hFE41, 1'b1, 1'b0, 8'h20);
    access(16'h2000, 1'b0, 1'b0, 8'h00);
    if (FAULT_EN) begin
      chk("plan_2000_irq", 32'(fault_irq), 1);
      chk("plan_2000_vaddr", 32'(fault_vaddr), 32'h2000);
      chk("plan_2000_data", 32'(last_data), 32'hFF);
    end
    access(16'hFF58, 1'b1, 1'b0, 8'h34);
    chk("plan_clr_irq", 32'(fault_irq), 0);

    // Entry 0x30: V=1, WP=1
    access(16'hFE61, 1'b1, 1'b0, 8'h30);
    access(16'h3000, 1'b1, 1'b0, 8'hC3);
    if (FAULT_EN) begin
      chk("plan_3000_nwe", 32'(last_nwe), 1);
      chk("plan_3000_irq", 32'(fault_irq), 1);
    end
    access(16'h3000, 1'b0, 1'b0, 8'h00);
    chk("plan_3000_rd_noe", 32'(last_noe), 0);

    // Reset mid-ACCESS with the CPU access left pending through INIT
    @(negedge clk);
    cpu_addr = 16'h12AB; nMREQ = 1'b0; nRD = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_pre_nce", 32'(ram_nCE), 0);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({ram_nCE, ram_nOE, ram_nWE}), 32'b111);
    chk("mid_rst_nwait", 32'(nWAIT), 0);
    cpu_addr = 16'hACFF;
    @(negedge clk);
    nRESET = 1'b1;
    model_reset();
    wait_init(n);
    chk("mid_init_len", 32'(n), 256);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_stall_nce", 32'(ram_nCE), 0);
    chk("mid_stall_addr", 32'(ram_addr), 32'h0ACFF);
    @(negedge clk);
    nMREQ = 1'b1; nRD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rel_nce", 32'(ram_nCE), 1);

    // Random mix of table writes, table reads and translated accesses
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)
        access(16'(WIN + 2 * int'($urandom_range(0, 253)) + int'($urandom_range(0, 1))),
               1'b1, 1'b0, 8'($urandom));
      else if (r == 1)
        access(16'(WIN + int'($urandom_range(0, 511))), 1'b0, 1'b0, 8'h00);
      else
        access(16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
